// File: rtl/turn_lever_conditioner.sv
// turn_lever_conditioner
// Front end for the tail-light sequencer. It conditions the raw turn-lever
// contacts into clean left and right requests that never overlap.
// The path is a 2-flop synchronizer, then a per-channel debounce, then a
// request FSM. The FSM adds a "comfort blink": a short tap keeps the request
// asserted for a fixed time after the lever is released.
// Optional feature: define HAZARD_SWITCH_EN to add the raw_hazard input and
// the HAZARD state, which drives left and right high together.
module turn_lever_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TAP_MAX_CYCLES  = 16,
  parameter int COMFORT_CYCLES  = 12,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_left,
  input  logic raw_right,
`ifdef HAZARD_SWITCH_EN
  input  logic raw_hazard,
`endif
  output logic left,
  output logic right,
  output logic comfort
);

  // Channel index map. The hazard channel exists only when the feature is built in.
  localparam int CH_L = 0;
  localparam int CH_R = 1;
`ifdef HAZARD_SWITCH_EN
  localparam int CH_H = 2;
  localparam int NCH  = 3;
`else
  localparam int NCH  = 2;
`endif

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TAP_MAX  = CNT_W'(TAP_MAX_CYCLES);
  localparam logic [CNT_W-1:0] CMF_INIT = CNT_W'(COMFORT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HOLD_L    = 3'd1,
    ST_HOLD_R    = 3'd2,
    ST_COMFORT_L = 3'd3,
    ST_COMFORT_R = 3'd4,
    ST_CONFLICT  = 3'd5
`ifdef HAZARD_SWITCH_EN
    , ST_HAZARD  = 3'd6
`endif
  } state_t;

  logic [NCH-1:0]            w_raw;
  logic [NCH-1:0]            r_s1;
  logic [NCH-1:0]            r_s2;
  logic [NCH-1:0]            r_deb;
  logic [NCH-1:0][CNT_W-1:0] r_dcnt;

  state_t                    r_state;
  state_t                    w_nxt;
  logic [CNT_W-1:0]          r_hold_cnt;
  logic [CNT_W-1:0]          r_cmf_cnt;

  logic                      w_deb_l;
  logic                      w_deb_r;
  logic                      w_clr;
  logic                      w_hold_entry;
  logic                      w_cmf_entry;
  logic                      w_left_nxt;
  logic                      w_right_nxt;
  logic                      w_comfort_nxt;
  logic                      r_left;
  logic                      r_right;
  logic                      r_comfort;

  assign w_raw[CH_L] = raw_left;
  assign w_raw[CH_R] = raw_right;
`ifdef HAZARD_SWITCH_EN
  assign w_raw[CH_H] = raw_hazard;
`endif

  assign w_deb_l = r_deb[CH_L];
  assign w_deb_r = r_deb[CH_R];

  // Two-flop synchronizer for every asynchronous contact.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
    end
  end

  // Per-channel debounce. A new level is accepted only after DEBOUNCE_CYCLES
  // consecutive samples that differ from the current level.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_deb  <= '0;
      r_dcnt <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (r_s2[c] == r_deb[c]) begin
          r_dcnt[c] <= '0;
        end else if (r_dcnt[c] == DEB_LAST) begin
          r_deb[c]  <= r_s2[c];
          r_dcnt[c] <= '0;
        end else begin
          r_dcnt[c] <= r_dcnt[c] + CNT_ONE;
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_nxt;
  end

  // Next-state logic. Priority order: hazard, then conflict, then opposite
  // lever, then same lever, then timeout.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_deb_l && w_deb_r) w_nxt = ST_CONFLICT;
        else if (w_deb_l)       w_nxt = ST_HOLD_L;
        else if (w_deb_r)       w_nxt = ST_HOLD_R;
      end
      ST_HOLD_L: begin
        if (w_deb_r)                     w_nxt = ST_CONFLICT;
        else if (!w_deb_l)               w_nxt = (r_hold_cnt < TAP_MAX) ? ST_COMFORT_L : ST_IDLE;
      end
      ST_HOLD_R: begin
        if (w_deb_l)                     w_nxt = ST_CONFLICT;
        else if (!w_deb_r)               w_nxt = (r_hold_cnt < TAP_MAX) ? ST_COMFORT_R : ST_IDLE;
      end
      ST_COMFORT_L: begin
        if (w_deb_l && w_deb_r)          w_nxt = ST_CONFLICT;
        else if (w_deb_r)                w_nxt = ST_HOLD_R;
        else if (w_deb_l)                w_nxt = ST_HOLD_L;
        else if (r_cmf_cnt == CNT_ONE)   w_nxt = ST_IDLE;
      end
      ST_COMFORT_R: begin
        if (w_deb_l && w_deb_r)          w_nxt = ST_CONFLICT;
        else if (w_deb_l)                w_nxt = ST_HOLD_L;
        else if (w_deb_r)                w_nxt = ST_HOLD_R;
        else if (r_cmf_cnt == CNT_ONE)   w_nxt = ST_IDLE;
      end
      ST_CONFLICT: begin
        if (!w_deb_l && !w_deb_r)        w_nxt = ST_IDLE;
      end
`ifdef HAZARD_SWITCH_EN
      ST_HAZARD: begin
        if (!r_deb[CH_H])                w_nxt = ST_IDLE;
      end
`endif
      default:                           w_nxt = ST_IDLE;
    endcase
`ifdef HAZARD_SWITCH_EN
    if (r_deb[CH_H]) w_nxt = ST_HAZARD;
`endif
  end

  // Decode the counter control events from the current/next state pair.
  always_comb begin
    w_clr = (r_state == ST_IDLE);
`ifdef HAZARD_SWITCH_EN
    w_clr = w_clr || (r_state == ST_HAZARD) || (w_nxt == ST_HAZARD);
`endif
    w_hold_entry = ((w_nxt == ST_HOLD_L) || (w_nxt == ST_HOLD_R)) && (w_nxt != r_state);
    w_cmf_entry  = ((r_state == ST_HOLD_L) && (w_nxt == ST_COMFORT_L)) ||
                   ((r_state == ST_HOLD_R) && (w_nxt == ST_COMFORT_R));
  end

  // Hold-time counter, which decides tap vs. hold, and the comfort countdown.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hold_cnt <= '0;
      r_cmf_cnt  <= '0;
    end else begin
      if (w_clr || w_hold_entry) begin
        r_hold_cnt <= '0;
      end else if (((r_state == ST_HOLD_L) || (r_state == ST_HOLD_R)) && (r_hold_cnt != TAP_MAX)) begin
        r_hold_cnt <= r_hold_cnt + CNT_ONE;
      end

      if (w_clr) begin
        r_cmf_cnt <= '0;
      end else if (w_cmf_entry) begin
        r_cmf_cnt <= CMF_INIT;
      end else if (((r_state == ST_COMFORT_L) || (r_state == ST_COMFORT_R)) && (r_cmf_cnt != '0)) begin
        r_cmf_cnt <= r_cmf_cnt - CNT_ONE;
      end
    end
  end

  // Output decode from the next state, so the registered outputs track the state register.
  always_comb begin
    w_left_nxt    = (w_nxt == ST_HOLD_L) || (w_nxt == ST_COMFORT_L);
    w_right_nxt   = (w_nxt == ST_HOLD_R) || (w_nxt == ST_COMFORT_R);
    w_comfort_nxt = (w_nxt == ST_COMFORT_L) || (w_nxt == ST_COMFORT_R);
`ifdef HAZARD_SWITCH_EN
    if (w_nxt == ST_HAZARD) begin
      w_left_nxt  = 1'b1;
      w_right_nxt = 1'b1;
    end
`endif
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_left    <= 1'b0;
      r_right   <= 1'b0;
      r_comfort <= 1'b0;
    end else begin
      r_left    <= w_left_nxt;
      r_right   <= w_right_nxt;
      r_comfort <= w_comfort_nxt;
    end
  end

  assign left    = r_left;
  assign right   = r_right;
  assign comfort = r_comfort;

endmodule
